// File: rtl/alu_clk_gate_pkg.sv
// Shared types and constants for the ALU clock-gate enable controller.
package alu_clk_gate_pkg;
  typedef enum logic [1:0] {IDLE, WAKE, ACTIVE, HOLD} gate_state_e;
  localparam int STATS_W = 16;
endpackage

// File: rtl/gate_dcnt.sv
// Loadable down-counter with zero flag, shared by the wake and idle-hold phases.
module gate_dcnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = load_val;
    else if (dec && cnt_q != '0)  cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/alu_clk_gate_ctrl.sv
// Registered CLK_EN controller for the ALU clock gate: wake delay, 1-deep request slot, idle hold.
// Optional GATE_STATS_EN adds ON_CYCLES, a saturating count of cycles with CLK_EN high.
module alu_clk_gate_ctrl
  import alu_clk_gate_pkg::*;
#(
  parameter int WAKE_CYCLES  = 2,
  parameter int IDLE_TIMEOUT = 8,
  parameter int CNT_W        = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic ALU_REQ,
  input  logic ALU_DONE,
  input  logic FORCE_ON,
  output logic CLK_EN,
  output logic ALU_GO,
  output logic BUSY,
  output logic REQ_DROP
`ifdef GATE_STATS_EN
  ,
  output logic [STATS_W-1:0] ON_CYCLES
`endif
);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_TIMEOUT - 1);

  gate_state_e      state_d, state_q;
  logic             pend_d, pend_q;
  logic             wait_d, wait_q;
  logic             clk_en_d, clk_en_q;
  logic             go_d, go_q;
  logic             busy_d, busy_q;
  logic             drop_d, drop_q;
  logic             pend_clr;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  gate_dcnt #(.CNT_W(CNT_W)) u_dcnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    wait_d   = wait_q;
    go_d     = 1'b0;
    drop_d   = 1'b0;
    pend_clr = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      IDLE: begin
        if (ALU_REQ) begin
          state_d  = WAKE;
          cnt_load = 1'b1;
          cnt_val  = WAKE_LD;
        end
      end
      WAKE: begin
        if (cnt_zero) begin
          state_d  = ACTIVE;
          go_d     = 1'b1;
          pend_clr = 1'b1;
          wait_d   = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ACTIVE: begin
        if (wait_q) begin
          // A request landing with DONE keeps us ACTIVE; GO follows next edge.
          if (ALU_DONE) begin
            wait_d = 1'b0;
            if (!pend_q && !ALU_REQ) begin
              state_d  = HOLD;
              cnt_load = 1'b1;
              cnt_val  = IDLE_LD;
            end
          end
        end else if (pend_q) begin
          go_d     = 1'b1;
          pend_clr = 1'b1;
          wait_d   = 1'b1;
        end else begin
          state_d  = HOLD;
          cnt_load = 1'b1;
          cnt_val  = IDLE_LD;
        end
      end
      HOLD: begin
        if (ALU_REQ)       state_d = ACTIVE;
        else if (cnt_zero) state_d = IDLE;
        else               cnt_dec = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (pend_clr) pend_d = 1'b0;
    // The slot frees on a GO edge, so a request there is accepted, not dropped.
    if (ALU_REQ) begin
      if (pend_q && !pend_clr) drop_d = 1'b1;
      else                     pend_d = 1'b1;
    end

    busy_d   = (state_d != IDLE);
    clk_en_d = busy_d | FORCE_ON;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      wait_q   <= 1'b0;
      clk_en_q <= 1'b0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      wait_q   <= wait_d;
      clk_en_q <= clk_en_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  assign CLK_EN   = clk_en_q;
  assign ALU_GO   = go_q;
  assign BUSY     = busy_q;
  assign REQ_DROP = drop_q;

`ifdef GATE_STATS_EN
  logic [STATS_W-1:0] on_cycles_d, on_cycles_q;

  always_comb begin
    on_cycles_d = on_cycles_q;
    if (clk_en_q && on_cycles_q != '1) on_cycles_d = on_cycles_q + STATS_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) on_cycles_q <= '0;
    else     on_cycles_q <= on_cycles_d;
  end

  assign ON_CYCLES = on_cycles_q;
`endif
endmodule
